io_multiplexer_staged_apb2_slave: RTL
=====================================

# io_multiplexer_staged_apb2_slave

Staged IO multiplexer: APB2-programmable physical↔logical pin map with separate shadow and active map banks. A commit sequence moves the shadow map into the active map with break-before-make. All physical drivers are released for a settle interval before the new map takes effect, so no pin is ever driven by two functions mid-reconfiguration. It sits between the FPGA pads and the peripheral cores, in the same place as the current multiplexer, and is its parametrised successor.

## Interface
- IO_PHYSICAL, 16: number of physical pins.
- IO_LOGICAL, 8: number of logical signals.
- ADDR_BITS, 12: APB address width.
- DATA_BITS, 8: APB data width; also the width of one map entry.
- SETTLE_CYCLES, 4: driver-release interval in cycles; values below 1 are treated as 1.
- clk  in  1  clock; sole clock domain.
- rst  in  1  synchronous, active-low reset.
- physical_in  in  IO_PHYSICAL  pad input values.
- physical_val  out  IO_PHYSICAL  pad output values.
- physical_drive  out  IO_PHYSICAL  pad output enables.
- logical_in  out  IO_LOGICAL  values routed to peripherals.
- logical_val  in  IO_LOGICAL  peripheral output values.
- logical_drive  in  IO_LOGICAL  peripheral output enables.
- PADDR  in  ADDR_BITS  APB2 address.
- PSEL, PENABLE, PWRITE  in  1 each  APB2 control.
- PWDATA  in  DATA_BITS  APB2 write data.
- PRDATA  out  DATA_BITS  APB2 read data; combinational from PADDR.

## Operation
- Write strobe is PSEL & PENABLE & PWRITE, sampled at the rising clk edge. There are no wait states.
- Register map:
  - 0x000+i: shadow physical map, i < IO_PHYSICAL. Value is the logical index.
  - 0x000+IO_PHYSICAL+j: shadow logical map. Value is the physical index.
  - 0x400+k: active map, same layout, read-only.
  - 0x800 CTRL, write-only:
    - bit0 COMMIT
    - bit1 REVERT (copy active to shadow)
    - bit2 clears ERR
  - 0x801 STATUS: bit0 BUSY, bit1 ERR (sticky), bits[7:2]=0.
  - 0x802 ID: constant 0x02.
- A map entry ≥ the opposite side's count, including 0xFF, means unmapped.
  - Unmapped physical pin: drive=0, val=0.
  - Unmapped logical signal: logical_in=0.
- Routing is combinational from the active map.
- Unused addresses read 0; writes to them and to read-only addresses are ignored.
- FSM states and transitions:
  - IDLE: accepts any write.
    - COMMIT → RELEASE, counter loaded with SETTLE_CYCLES−1.
    - REVERT → copy active to shadow in the same edge; stays in IDLE.
  - RELEASE: physical_drive forced to all 0; logical_in forced to 0. Counter decrements each cycle. At 0 → APPLY.
  - APPLY: one cycle; active ← shadow; outputs still forced. → IDLE.
- While BUSY (state ≠ IDLE):
  - Shadow writes and COMMIT/REVERT are ignored and set ERR.
  - A bit2 write clears ERR; this is permitted.
- A CTRL write with both COMMIT and REVERT set does nothing and sets ERR. bit2 in the same write is still honoured, and clear wins over set.
- A shadow write and a COMMIT on different cycles work normally. The latest shadow value before the COMMIT edge is applied.

## Timing
- Reset (rst=0 at an edge):
  - All shadow and active entries = 0xFF.
  - State IDLE, counter 0, BUSY=0, ERR=0.
  - Hence physical_drive=0, physical_val=0, logical_in=0.
- Reset asserted mid-commit aborts immediately to the reset state. The pending shadow is lost.
- COMMIT accepted at edge T:
  - Drivers are released from T+1.
  - BUSY=1 for SETTLE_CYCLES+1 cycles.
  - The new map drives outputs from edge T+SETTLE_CYCLES+1 onward.
- Register writes are visible on PRDATA in the cycle after the write edge.
- No pipeline on the data path. Input-to-output routing is combinational in every state except that it is forced off during RELEASE and APPLY.

## Structure
- Shared package holds:
  - register offsets (SHADOW_BASE, ACTIVE_BASE, CTRL, STATUS, ID)
  - UNMAPPED = 8'hFF
  - ID value
  - FSM state encodings (IDLE, RELEASE, APPLY)
- Reuse the existing pin_mux sub-module for routing, fed from the active bank.
- Gate its physical_drive and logical_in outputs with the release condition in this block.
- Register file, APB decode and FSM live in this module.

## Test plan
- Reset with rst=0 for 2 cycles → all maps read 0xFF, STATUS=0x00, physical_drive=0, ID reads 0x02.
- Shadow phys[3]=2, log[2]=3, then COMMIT, SETTLE_CYCLES=4, logical_drive[2]=1, logical_val[2]=1:
  - BUSY=1 for 5 cycles and physical_drive=0 throughout.
  - physical_drive[3]=1 and physical_val[3]=1 from T+5.
  - physical_in[3] toggling then appears on logical_in[2].
- With a map active, remap phys[3] to logical 5 and COMMIT → physical_drive[3] is 0 for the entire release window (break-before-make), then follows logical 5.
- Shadow write and second COMMIT during BUSY → ignored, STATUS=0x03. After completion, a CTRL bit2 write gives STATUS=0x00.
- Modify shadow, REVERT in IDLE → shadow reads equal the active map the next cycle. A CTRL write of 0x03 → no action, ERR=1.
- rst=0 during RELEASE → next cycle IDLE, all maps 0xFF, outputs 0. Entries of 0x10 (out of range, IO_LOGICAL=8) behave as unmapped.

Source files
------------

// File: rtl/io_multiplexer_staged_apb2_slave_pkg.sv
// Shared constants, register offsets and FSM encoding for the staged IO multiplexer.
package io_multiplexer_staged_apb2_slave_pkg;

  localparam logic [11:0] SHADOW_BASE = 12'h000;
  localparam logic [11:0] ACTIVE_BASE = 12'h400;
  localparam logic [11:0] CTRL_ADDR   = 12'h800;
  localparam logic [11:0] STATUS_ADDR = 12'h801;
  localparam logic [11:0] ID_ADDR     = 12'h802;

  localparam logic [7:0] UNMAPPED = 8'hFF;
  localparam logic [7:0] ID_VALUE = 8'h02;

  // CTRL write payload, low three bits of PWDATA
  typedef struct packed {
    logic clear_err;
    logic revert;
    logic commit;
  } ctrl_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  // Index width for n items, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_multiplexer_staged_apb2_slave_if.sv
// APB2 slave bus bundle for the staged IO multiplexer.
interface io_multiplexer_staged_apb2_slave_if #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_BITS-1:0] PWDATA;
  logic [DATA_BITS-1:0] PRDATA;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA);
  modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA);
endinterface

// File: rtl/io_multiplexer_staged_apb2_slave_pin_mux.sv
// Combinational physical<->logical router; out-of-range map entries are unmapped.
module io_multiplexer_staged_apb2_slave_pin_mux #(
  parameter int unsigned IO_PHYSICAL = 16,
  parameter int unsigned IO_LOGICAL  = 8,
  parameter int unsigned DATA_BITS   = 8
) (
  input  logic [IO_PHYSICAL-1:0][DATA_BITS-1:0] phys_map,
  input  logic [IO_LOGICAL-1:0][DATA_BITS-1:0]  log_map,
  input  logic [IO_PHYSICAL-1:0]                physical_in,
  output logic [IO_PHYSICAL-1:0]                physical_val,
  output logic [IO_PHYSICAL-1:0]                physical_drive,
  output logic [IO_LOGICAL-1:0]                 logical_in,
  input  logic [IO_LOGICAL-1:0]                 logical_val,
  input  logic [IO_LOGICAL-1:0]                 logical_drive
);
  import io_multiplexer_staged_apb2_slave_pkg::*;

  localparam int unsigned LIDX_BITS = clog2_min1(IO_LOGICAL);
  localparam int unsigned PIDX_BITS = clog2_min1(IO_PHYSICAL);

  // Each pad follows the logical signal it names
  always_comb begin
    physical_val   = '0;
    physical_drive = '0;
    for (int i = 0; i < IO_PHYSICAL; i++) begin
      if (phys_map[i] < DATA_BITS'(IO_LOGICAL)) begin
        physical_val[i]   = logical_val[LIDX_BITS'(phys_map[i])];
        physical_drive[i] = logical_drive[LIDX_BITS'(phys_map[i])];
      end
    end
  end

  // Each logical input samples the pad it names
  always_comb begin
    logical_in = '0;
    for (int j = 0; j < IO_LOGICAL; j++) begin
      if (log_map[j] < DATA_BITS'(IO_PHYSICAL)) begin
        logical_in[j] = physical_in[PIDX_BITS'(log_map[j])];
      end
    end
  end

endmodule

// File: rtl/io_multiplexer_staged_apb2_slave.sv
// Staged IO multiplexer: APB2 shadow/active map banks with break-before-make commit.
module io_multiplexer_staged_apb2_slave
  import io_multiplexer_staged_apb2_slave_pkg::*;
#(
  parameter int unsigned IO_PHYSICAL   = 16,
  parameter int unsigned IO_LOGICAL    = 8,
  parameter int unsigned ADDR_BITS     = 12,
  parameter int unsigned DATA_BITS     = 8,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IO_PHYSICAL-1:0] physical_in,
  output logic [IO_PHYSICAL-1:0] physical_val,
  output logic [IO_PHYSICAL-1:0] physical_drive,
  output logic [IO_LOGICAL-1:0]  logical_in,
  input  logic [IO_LOGICAL-1:0]  logical_val,
  input  logic [IO_LOGICAL-1:0]  logical_drive,
  io_multiplexer_staged_apb2_slave_if.slave apb
);

  localparam int unsigned SETTLE_EFF     = (SETTLE_CYCLES < 1) ? 32'd1 : 32'(SETTLE_CYCLES);
  localparam int unsigned NUM_ENTRIES    = IO_PHYSICAL + IO_LOGICAL;
  localparam int unsigned ENTRY_IDX_BITS = clog2_min1(NUM_ENTRIES);
  localparam int unsigned CNT_BITS       = clog2_min1(SETTLE_EFF);

  logic [NUM_ENTRIES-1:0][DATA_BITS-1:0] shadow_q;
  logic [NUM_ENTRIES-1:0][DATA_BITS-1:0] active_q;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                      wr;
  logic [ADDR_BITS-1:0]      sh_off, ac_off;
  logic [ENTRY_IDX_BITS-1:0] sh_idx, ac_idx;
  logic                      sh_hit, ac_hit, ctrl_hit, status_hit, id_hit;
  ctrl_cmd_t                 cmd;
  logic                      busy;
  logic                      shadow_we, do_revert, do_apply;
  logic [DATA_BITS-1:0]      prdata;

  logic [IO_PHYSICAL-1:0] mux_drive;
  logic [IO_LOGICAL-1:0]  mux_logical_in;

  // APB decode
  assign wr         = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign sh_off     = apb.PADDR - ADDR_BITS'(SHADOW_BASE);
  assign ac_off     = apb.PADDR - ADDR_BITS'(ACTIVE_BASE);
  assign sh_hit     = sh_off < ADDR_BITS'(NUM_ENTRIES);
  assign ac_hit     = ac_off < ADDR_BITS'(NUM_ENTRIES);
  assign sh_idx     = ENTRY_IDX_BITS'(sh_off);
  assign ac_idx     = ENTRY_IDX_BITS'(ac_off);
  assign ctrl_hit   = apb.PADDR == ADDR_BITS'(CTRL_ADDR);
  assign status_hit = apb.PADDR == ADDR_BITS'(STATUS_ADDR);
  assign id_hit     = apb.PADDR == ADDR_BITS'(ID_ADDR);
  assign cmd        = ctrl_cmd_t'(apb.PWDATA[2:0]);
  assign busy       = state_q != ST_IDLE;

  // Combinational read mux; unused and write-only addresses read zero
  always_comb begin
    prdata = '0;
    if (sh_hit) begin
      prdata = shadow_q[sh_idx];
    end else if (ac_hit) begin
      prdata = active_q[ac_idx];
    end else if (status_hit) begin
      prdata = DATA_BITS'({err_q, busy});
    end else if (id_hit) begin
      prdata = DATA_BITS'(ID_VALUE);
    end
  end
  assign apb.PRDATA = prdata;

  // FSM state, settle counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and bank-update strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    shadow_we = 1'b0;
    do_revert = 1'b0;
    do_apply  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        shadow_we = wr & sh_hit;
        if (wr && ctrl_hit) begin
          if (cmd.commit && cmd.revert) begin
            err_d = 1'b1;
          end else if (cmd.commit) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_BITS'(SETTLE_EFF - 1);
          end else if (cmd.revert) begin
            do_revert = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      ST_APPLY: begin
        do_apply = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Map changes requested mid-reconfiguration are refused and flagged
    if (busy && wr && (sh_hit || (ctrl_hit && (cmd.commit || cmd.revert)))) begin
      err_d = 1'b1;
    end
    // Error clear is always honoured and wins over a simultaneous set
    if (wr && ctrl_hit && cmd.clear_err) begin
      err_d = 1'b0;
    end
  end

  // Shadow and active map banks
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= {NUM_ENTRIES{DATA_BITS'(UNMAPPED)}};
      active_q <= {NUM_ENTRIES{DATA_BITS'(UNMAPPED)}};
    end else begin
      if (shadow_we) begin
        shadow_q[sh_idx] <= apb.PWDATA;
      end
      if (do_revert) begin
        shadow_q <= active_q;
      end
      if (do_apply) begin
        active_q <= shadow_q;
      end
    end
  end

  io_multiplexer_staged_apb2_slave_pin_mux #(
    .IO_PHYSICAL (IO_PHYSICAL),
    .IO_LOGICAL  (IO_LOGICAL),
    .DATA_BITS   (DATA_BITS)
  ) u_pin_mux (
    .phys_map       (active_q[IO_PHYSICAL-1:0]),
    .log_map        (active_q[NUM_ENTRIES-1:IO_PHYSICAL]),
    .physical_in    (physical_in),
    .physical_val   (physical_val),
    .physical_drive (mux_drive),
    .logical_in     (mux_logical_in),
    .logical_val    (logical_val),
    .logical_drive  (logical_drive)
  );

  // Break-before-make: all drivers and inputs held off while reconfiguring
  assign physical_drive = mux_drive & {IO_PHYSICAL{~busy}};
  assign logical_in     = mux_logical_in & {IO_LOGICAL{~busy}};

endmodule
